// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory for the fetch stage: assembles streamed
// bytes into words during LOAD, then serves registered, address-checked fetches in RUN.
module instr_mem_loader #(
  parameter int unsigned      NBITS     = 32,
  parameter int unsigned      DEPTH     = 64,
  parameter logic [NBITS-1:0] HALT_WORD = '1,
  parameter logic [NBITS-1:0] NOP_WORD  = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load_start,
  input  logic                        i_byte_valid,
  input  logic [7:0]                  i_byte,
  output logic                        o_byte_ready,
  output logic                        o_load_done,
  output logic                        o_load_ovf,
  output logic [$clog2(DEPTH):0]      o_word_count,
  input  logic                        i_fetch_en,
  input  logic                        i_flush,
  input  logic [NBITS-1:0]            i_PC,
  output logic [NBITS-1:0]            o_Instruction,
  output logic                        o_halt,
  output logic                        o_addr_err
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned SHIFT_W = NBITS - 8;
  localparam int unsigned WADDR_W = NBITS - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               byte_ready_q, byte_ready_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [NBITS-1:0]   instr_q, instr_d;
  logic               halt_q, halt_d;
  logic               err_q, err_d;

  logic [NBITS-1:0]   mem [DEPTH];
  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_waddr_c;
  logic [NBITS-1:0]   word_c;
  logic [NBITS-1:0]   rd_data_c;
  logic               byte_acc_c;
  logic               pc_bad_c;

  assign byte_acc_c  = i_byte_valid && byte_ready_q;
  assign word_c      = {shift_q, i_byte};
  assign mem_waddr_c = count_q[ADDR_W-1:0];
  assign rd_data_c   = mem[i_PC[ADDR_W+1:2]];
  // Word-index compare over the full PC also rejects high bits beyond the array.
  assign pc_bad_c    = (i_PC[1:0] != 2'b00) ||
                       (i_PC[NBITS-1:2] >= WADDR_W'(count_q));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    instr_d    = instr_q;
    err_d      = err_q;
    mem_we_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        instr_d = NOP_WORD;
        err_d   = 1'b0;
      end
      S_LOAD: begin
        instr_d = NOP_WORD;
        err_d   = 1'b0;
        if (byte_acc_c) begin
          if (byte_cnt_q == 2'd3) begin
            mem_we_c   = 1'b1;
            count_d    = count_q + CNT_W'(1);
            byte_cnt_d = 2'd0;
            if (word_c == HALT_WORD) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else if (count_q == CNT_W'(DEPTH - 1)) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              ovf_d   = 1'b1;
            end
          end else begin
            shift_d    = {shift_q[SHIFT_W-9:0], i_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_RUN: begin
        if (i_flush) begin
          instr_d = NOP_WORD;
          err_d   = 1'b0;
        end else if (i_fetch_en) begin
          if (pc_bad_c) begin
            instr_d = NOP_WORD;
            err_d   = 1'b1;
          end else begin
            instr_d = rd_data_c;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load start from any state (re)opens a fresh load and discards partial bytes.
    if (i_load_start) begin
      state_d    = S_LOAD;
      byte_cnt_d = 2'd0;
      count_d    = '0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
      instr_d    = NOP_WORD;
      err_d      = 1'b0;
      mem_we_c   = 1'b0;
    end

    byte_ready_d = (state_d == S_LOAD);
    halt_d       = (state_d == S_RUN) && (instr_d == HALT_WORD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      shift_q      <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      instr_q      <= NOP_WORD;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      instr_q      <= instr_d;
      halt_q       <= halt_d;
      err_q        <= err_d;
    end
  end

  // Program storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= word_c;
    end
  end

  assign o_byte_ready  = byte_ready_q;
  assign o_load_done   = done_q;
  assign o_load_ovf    = ovf_q;
  assign o_word_count  = count_q;
  assign o_Instruction = instr_q;
  assign o_halt        = halt_q;
  assign o_addr_err    = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (DEPTH = 4): byte loading, fetch rules,
// overflow, restart and asynchronous reset.
module tb_instr_mem_loader;

  localparam int unsigned NBITS = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic             clk;
  logic             rst_n;
  logic             load_start;
  logic             byte_valid;
  logic [7:0]       byte_in;
  logic             byte_ready;
  logic             load_done;
  logic             load_ovf;
  logic [CNT_W-1:0] word_count;
  logic             fetch_en;
  logic             flush;
  logic [NBITS-1:0] pc;
  logic [NBITS-1:0] instr;
  logic             halt;
  logic             addr_err;

  instr_mem_loader #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_start (load_start),
    .i_byte_valid (byte_valid),
    .i_byte       (byte_in),
    .o_byte_ready (byte_ready),
    .o_load_done  (load_done),
    .o_load_ovf   (load_ovf),
    .o_word_count (word_count),
    .i_fetch_en   (fetch_en),
    .i_flush      (flush),
    .i_PC         (pc),
    .o_Instruction(instr),
    .o_halt       (halt),
    .o_addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        halt;
    logic        err;
  } fetch_t;

  fetch_t      sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_cnt     = 0;
  logic        m_loading = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_ovf     = 1'b0;
  int          m_nbytes  = 0;
  logic [31:0] m_acc     = '0;
  logic [31:0] e_instr   = '0;
  logic        e_err     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".ready"}, 32'(byte_ready), 32'(m_loading));
    check({tag, ".done"},  32'(load_done),  32'(m_done));
    check({tag, ".ovf"},   32'(load_ovf),   32'(m_ovf));
    check({tag, ".count"}, 32'(word_count), 32'(m_cnt));
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    m_loading = 1'b1;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
    m_nbytes  = 0;
    e_instr   = '0;
    e_err     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (m_loading) begin
      m_acc = {m_acc[23:0], b};
      m_nbytes++;
      if (m_nbytes == 4) begin
        m_nbytes = 0;
        m_mem[m_cnt] = m_acc;
        m_cnt++;
        if (m_acc == HALT) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end else if (m_cnt == DEPTH) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
          m_ovf     = 1'b1;
        end
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  // Predict the RUN-state fetch result, then compare what the DUT registers.
  task automatic fetch(input logic [31:0] a, input logic fe, input logic fl, input string tag);
    fetch_t exp_f;
    fetch_t got_f;
    if (fl) begin
      e_instr = '0;
      e_err   = 1'b0;
    end else if (fe) begin
      if (a[1:0] != 2'b00 || int'(a[31:2]) >= m_cnt || a[31:2] >= 30'(DEPTH)) begin
        e_instr = '0;
        e_err   = 1'b1;
      end else begin
        e_instr = m_mem[a[3:2]];
        e_err   = 1'b0;
      end
    end
    exp_f.instr = e_instr;
    exp_f.halt  = (e_instr == HALT);
    exp_f.err   = e_err;
    sb_q.push_back(exp_f);
    @(negedge clk);
    pc       = a;
    fetch_en = fe;
    flush    = fl;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    fetch_en = 1'b1;
    got_f = sb_q.pop_front();
    check({tag, ".instr"}, instr,            got_f.instr);
    check({tag, ".halt"},  32'(halt),        32'(got_f.halt));
    check({tag, ".err"},   32'(addr_err),    32'(got_f.err));
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, ".instr"}, instr,            32'h0);
    check({tag, ".halt"},  32'(halt),        32'h0);
    check({tag, ".err"},   32'(addr_err),    32'h0);
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
    m_nbytes  = 0;
    e_instr   = '0;
    e_err     = 1'b0;
    check_status(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    fetch_en   = 1'b1;
    flush      = 1'b0;
    pc         = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.instr", instr, 32'h0);
    check_status("rst");

    // Basic program: two instructions then HALT.
    start_load();
    check_status("load_entry");
    send_word(32'h2001_0005);
    send_word(32'h0022_1820);
    send_word(HALT);
    check_status("load3");

    fetch(32'd0,  1'b1, 1'b0, "pc0");
    fetch(32'd8,  1'b1, 1'b0, "pc8_halt");
    fetch(32'd4,  1'b0, 1'b0, "stall");
    fetch(32'd4,  1'b1, 1'b1, "flush");
    fetch(32'd6,  1'b1, 1'b0, "misalign");
    fetch(32'd12, 1'b1, 1'b0, "beyond_cnt");
    fetch(32'd4,  1'b1, 1'b0, "pc4");
    fetch(32'h1000_0000, 1'b1, 1'b0, "high_pc");
    fetch(32'd0,  1'b0, 1'b1, "flush_stall");
    fetch(32'd0,  1'b1, 1'b0, "pc0_again");

    // Bytes offered outside LOAD are not taken.
    send_word(32'h1234_5678);
    check_status("drop_run");

    fetch(32'd8, 1'b1, 1'b0, "pre_rst");
    mid_reset("rst_run");

    // Restart mid-load discards partial bytes.
    start_load();
    send_byte(8'hAA);
    send_byte(8'hBB);
    start_load();
    send_word(32'h1122_3344);
    send_word(HALT);
    check_status("restart");
    fetch(32'd0, 1'b1, 1'b0, "restart_w0");
    fetch(32'd4, 1'b1, 1'b0, "restart_w1");
    fetch(32'd8, 1'b1, 1'b0, "restart_oob");

    // Reload from RUN, then fill the array with no HALT.
    start_load();
    check("reload.instr", instr, 32'h0);
    check_status("reload");
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(32'h090A_0B0C);
    send_word(32'h0D0E_0F10);
    check_status("ovf");
    send_word(32'h5566_7788);
    check_status("ovf_drop");
    fetch(32'd12, 1'b1, 1'b0, "ovf_w3");
    fetch(32'd16, 1'b1, 1'b0, "ovf_oob");
    fetch(32'd0,  1'b1, 1'b0, "ovf_w0");

    // HALT as the last possible word ends the load without overflow.
    start_load();
    send_word(32'hA0A0_A0A0);
    send_word(32'hB0B0_B0B0);
    send_word(32'hC0C0_C0C0);
    send_word(HALT);
    check_status("halt_last");
    fetch(32'd12, 1'b1, 1'b0, "halt_last_w3");
    fetch(32'd8,  1'b1, 1'b0, "halt_last_w2");

    // Asynchronous reset in the middle of a load.
    start_load();
    send_byte(8'h01);
    send_byte(8'h02);
    mid_reset("rst_load");
    @(posedge clk);
    #1;
    check_status("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
